// File: rtl/accum8_pkg.sv
// Shared definitions for the accum8_ctrl burst accumulator: state encoding,
// default burst length and a small incrementer.
package accum8_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam int N_SAMPLES_DEF = 4;

  // Ripple incrementer so the counter needs no behavioural adder either.
  function automatic logic [3:0] inc4(input logic [3:0] v);
    logic [3:0] r;
    logic       c;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder8bit.sv
// 8-bit ripple-carry adder with carry out and two's-complement overflow flag.
module adder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf  = c[8] ^ c[7];

endmodule

// File: rtl/accum8_ctrl.sv
// Burst accumulator: sums/subtracts N_SAMPLES signed bytes, saturating a
// step to zero on signed overflow, then holds the result for a handshake.
//
//   state  | meaning
//   ST_ACC | collecting operands, in_ready=1
//   ST_OUT | holding burst result, out_valid=1
module accum8_ctrl
  import accum8_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_sub,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_ovf,
  output logic [3:0] out_cnt
);

  localparam logic [3:0] CNT_LAST = 4'(N_SAMPLES);

  state_t     state, state_nx;
  logic [7:0] acc, acc_nx;
  logic       ovf, ovf_nx;
  logic [3:0] cnt, cnt_nx;

  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       add_ovf;
  logic       unused_cout;

  assign add_b = in_sub ? ~in_data : in_data;

  adder8bit u_add (
    .a   (acc),
    .b   (add_b),
    .cin (in_sub),
    .sum (add_sum),
    .cout(add_cout),
    .ovf (add_ovf)
  );

  // Unsigned carry has no meaning for signed accumulation.
  assign unused_cout = add_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ACC;
      acc   <= 8'h00;
      ovf   <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      ovf   <= ovf_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ovf_nx   = ovf;
    cnt_nx   = cnt;
    if (clr) begin
      state_nx = ST_ACC;
      acc_nx   = 8'h00;
      ovf_nx   = 1'b0;
      cnt_nx   = 4'd0;
    end else if (state == ST_ACC) begin
      if (in_valid) begin
        acc_nx = add_ovf ? 8'h00 : add_sum;
        ovf_nx = ovf | add_ovf;
        cnt_nx = inc4(cnt);
        if (inc4(cnt) == CNT_LAST) state_nx = ST_OUT;
      end
    end else if (out_ready) begin
      state_nx = ST_ACC;
      acc_nx   = 8'h00;
      ovf_nx   = 1'b0;
      cnt_nx   = 4'd0;
    end
  end

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_cnt   = cnt;

endmodule

// File: tb/tb_accum8_ctrl.sv
// Directed vector bench for accum8_ctrl with N_SAMPLES=4.
module tb_accum8_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic [3:0] out_cnt;

  int checks = 0;
  int errors = 0;

  accum8_ctrl #(.N_SAMPLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .out_cnt  (out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] data;
    logic       sub;
    logic       ordy;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_sum;
    logic       e_ovf;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic v, logic [7:0] d, logic s, logic o,
                              logic er, logic ev, logic [7:0] es, logic eo, logic [3:0] ec);
    vec_t t;
    t.clr = c; t.vld = v; t.data = d; t.sub = s; t.ordy = o;
    t.e_rdy = er; t.e_vld = ev; t.e_sum = es; t.e_ovf = eo; t.e_cnt = ec;
    return t;
  endfunction

  task automatic check(string name, logic er, logic ev, logic [7:0] es, logic eo, logic [3:0] ec);
    checks++;
    if ({in_ready, out_valid, out_sum, out_ovf, out_cnt} !== {er, ev, es, eo, ec}) begin
      errors++;
      $display("FAIL %s: got rdy=%b vld=%b sum=%h ovf=%b cnt=%0d, want rdy=%b vld=%b sum=%h ovf=%b cnt=%0d",
               name, in_ready, out_valid, out_sum, out_ovf, out_cnt, er, ev, es, eo, ec);
    end
  endtask

  task automatic drive(logic c, logic v, logic [7:0] d, logic s, logic o);
    clr = c; in_valid = v; in_data = d; in_sub = s; out_ready = o;
  endtask

  initial begin
    // clr vld data sub ordy | rdy vld sum ovf cnt (after the edge)
    vecs.push_back(mk(0,1,8'd10, 0,0, 1,0,8'h0A,0,1));
    vecs.push_back(mk(0,1,8'd20, 0,0, 1,0,8'h1E,0,2));
    vecs.push_back(mk(0,1,8'd30, 0,0, 1,0,8'h3C,0,3));
    vecs.push_back(mk(0,1,8'd40, 0,0, 0,1,8'h64,0,4));
    vecs.push_back(mk(0,1,8'd7,  0,0, 0,1,8'h64,0,4));
    vecs.push_back(mk(0,1,8'd7,  0,0, 0,1,8'h64,0,4));
    vecs.push_back(mk(0,1,8'd7,  0,0, 0,1,8'h64,0,4));
    vecs.push_back(mk(0,1,8'd7,  0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'd100,0,0, 1,0,8'h64,0,1));
    vecs.push_back(mk(0,1,8'd50, 0,0, 1,0,8'h00,1,2));
    vecs.push_back(mk(0,1,8'd5,  0,0, 1,0,8'h05,1,3));
    vecs.push_back(mk(0,1,8'd5,  0,0, 0,1,8'h0A,1,4));
    vecs.push_back(mk(0,0,8'd0,  0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'd5,  1,0, 1,0,8'hFB,0,1));
    vecs.push_back(mk(0,1,8'd5,  1,0, 1,0,8'hF6,0,2));
    vecs.push_back(mk(0,1,8'd5,  1,0, 1,0,8'hF1,0,3));
    vecs.push_back(mk(0,1,8'd5,  1,0, 0,1,8'hEC,0,4));
    vecs.push_back(mk(0,0,8'd0,  0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'h80, 0,0, 1,0,8'h80,0,1));
    vecs.push_back(mk(0,1,8'd1,  1,0, 1,0,8'h00,1,2));
    vecs.push_back(mk(1,1,8'd9,  0,0, 1,0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'd1,  0,0, 1,0,8'h01,0,1));
    vecs.push_back(mk(0,1,8'd1,  0,0, 1,0,8'h02,0,2));
    vecs.push_back(mk(0,1,8'd1,  0,0, 1,0,8'h03,0,3));
    vecs.push_back(mk(0,1,8'd1,  0,0, 0,1,8'h04,0,4));
    vecs.push_back(mk(1,1,8'd1,  0,0, 1,0,8'h00,0,0));
    vecs.push_back(mk(0,1,8'd5,  0,0, 1,0,8'h05,0,1));
    vecs.push_back(mk(0,1,8'hFF, 0,0, 1,0,8'h04,0,2));
    vecs.push_back(mk(0,1,8'd0,  1,0, 1,0,8'h04,0,3));
    vecs.push_back(mk(0,0,8'd0,  0,0, 1,0,8'h04,0,3));
    vecs.push_back(mk(1,0,8'd0,  0,0, 1,0,8'h00,0,0));

    #1;
    check("reset_async", 1, 0, 8'h00, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].vld, vecs[i].data, vecs[i].sub, vecs[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_sum,
            vecs[i].e_ovf, vecs[i].e_cnt);
    end

    // Reach OUT, then pulse rst between edges.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'd2, 0, 0);
      @(posedge clk);
      #1;
    end
    check("pre_rst_out", 0, 1, 8'h08, 0, 4);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out", 1, 0, 8'h00, 0, 0);
    #1 rst = 1'b0;
    drive(0, 0, 8'd0, 0, 1);
    @(posedge clk);
    #1;
    check("post_rst_idle", 1, 0, 8'h00, 0, 0);
    drive(0, 1, 8'd3, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_first", 1, 0, 8'h03, 0, 1);

    // Reset mid-burst also discards the partial sum.
    #2 rst = 1'b1;
    #1;
    check("rst_mid_burst", 1, 0, 8'h00, 0, 0);
    #1 rst = 1'b0;
    drive(0, 1, 8'd9, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_new_burst", 1, 0, 8'h09, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum8_ctrl.md
ACCUM8_CTRL -- requirements
Module: accum8_ctrl

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 4, meaning operands accepted per accumulation burst (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port clr  input  1  synchronous burst abort/clear.
REQ-005 SHALL have port in_valid  input  1  operand present.
REQ-006 SHALL have port in_ready  output  1  block can accept operand.
REQ-007 SHALL have port in_data  input  8  signed two's-complement operand.
REQ-008 SHALL have port in_sub  input  1  sampled with in_data; 1 = subtract operand, 0 = add.
REQ-009 SHALL have port out_valid  output  1  burst result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  8  signed burst result.
REQ-012 SHALL have port out_ovf  output  1  sticky: at least one step of burst overflowed.
REQ-013 SHALL have port out_cnt  output  4  operands accepted in current burst.

Function
REQ-014 SHALL implement two states: ACC (collecting) and OUT (holding result).
REQ-015 In ACC, in_ready SHALL be 1 and out_valid 0; in OUT, in_ready SHALL be 0 and out_valid 1.
REQ-016 Operand accepted on a rising edge where in_valid=1 and in_ready=1 and clr=0.
REQ-017 On accept, acc SHALL update that edge to acc+in_data (in_sub=0) or acc+~in_data+1 (in_sub=1), computed by the adder sub-module with Cin=in_sub.
REQ-018 Adder step with signed overflow (carry into bit 7 XOR carry out) SHALL yield acc=0x00 for that step and set sticky ovf; accumulation continues from 0x00.
REQ-019 Unsigned carry out SHALL be ignored when signed overflow is absent.
REQ-020 On accept, cnt SHALL increment; on the accept making cnt=N_SAMPLES, state SHALL go to OUT; out_valid asserts the following cycle (1-cycle latency from last accept).
REQ-021 In OUT, out_sum=acc, out_ovf=ovf, out_cnt=N_SAMPLES SHALL be held stable until out_ready=1.
REQ-022 On edge with out_valid=1 and out_ready=1, SHALL clear acc, ovf, cnt and return to ACC; no operand accepted that edge (in_ready was 0).
REQ-023 clr=1 SHALL, at the edge, clear acc, ovf, cnt and force ACC, discarding any in_valid or pending result; clr has priority over both handshakes.
REQ-024 in_valid without accept (in_ready=0 or clr=1) SHALL leave state unchanged.
REQ-025 In ACC, out_sum/out_ovf SHALL reflect running acc/ovf (informational, not valid).

Reset
REQ-026 rst=1 SHALL immediately, without clock, set state=ACC, acc=0x00, ovf=0, cnt=0.
REQ-027 Resulting outputs SHALL be in_ready=1, out_valid=0, out_sum=0x00, out_ovf=0, out_cnt=0.
REQ-028 Reset mid-burst or in OUT SHALL discard all partial/pending results; first accept after release starts a new burst.

Structure
REQ-029 State encoding constants (ACC, OUT) and default N_SAMPLES SHALL live in shared package accum8_pkg.
REQ-030 Addition SHALL be performed by one instance of the team's existing 8-bit ripple adder adder8bit (A=acc, B=in_data or ~in_data, Cin=in_sub, overflow output drives ovf); no behavioural "+" in this block.
REQ-031 acc, ovf, cnt, state SHALL be the only registers; in_ready/out_valid decoded from state.

Verification
REQ-032 N=4, add 10,20,30,40 back-to-back -> out_valid 1 cycle after 4th accept, out_sum=0x64, out_ovf=0, out_cnt=4.
REQ-033 Add 100,50 (overflow -> acc 0x00), then add 5,5 -> out_sum=0x0A, out_ovf=1.
REQ-034 Subtract 5 four times -> out_sum=0xEC (-20), out_ovf=0; subtract 1 from -128 step -> acc=0x00, ovf=1.
REQ-035 Hold out_ready=0 for 3 cycles in OUT with in_valid=1 -> out_valid stays 1, in_ready 0, out_sum stable, no operand consumed; then out_ready=1 -> ACC, cnt=0.
REQ-036 clr asserted after 2 accepts together with in_valid=1 -> operand discarded, cnt=0, acc=0x00; next 4 adds of 1 -> out_sum=0x04.
REQ-037 rst pulsed between clock edges during OUT -> out_valid drops immediately, all outputs at reset values.
